// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port data memory
// between NUM_CORES cores. Each served access takes three cycles
// (IDLE -> ACCESS -> DONE). The served core gets a one-cycle done pulse,
// with rdata valid for reads.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req/we              per-core request and write enable (held until done)
//   addr/wdata          per-core address/data, core i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt                 one-hot grant, high in ACCESS and DONE
//   done                one-hot completion pulse, high in DONE
//   rdata               captured read data, valid while done is high
//   busy                high whenever not IDLE
//   mem_we/addr/wd      shared memory port
//   mem_rd              shared memory read data (combinational from mem_addr)
module dmem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(NUM_CORES)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            req,
  input  logic [NUM_CORES-1:0]            we,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] wdata,
  output logic [NUM_CORES-1:0]            gnt,
  output logic [NUM_CORES-1:0]            done,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            busy,
  output logic                            mem_we,
  output logic [DATA_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wd,
  input  logic [DATA_WIDTH-1:0]           mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

  stateT                 state, stateNext;
  logic [IDX_W-1:0]      ptr, winQ, winNext;
  logic                  weQ;
  logic [DATA_WIDTH-1:0] addrQ, wdQ, rdataQ;
  logic [NUM_CORES-1:0]  lowMask, hiReq;
  logic                  granting;

  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] addrVec, wdVec;

  assign granting = (state == ACCESS) || (state == DONE);

  // Requests at or above ptr take priority; lowMask covers indices below ptr.
  assign lowMask = (NUM_CORES'(1) << ptr) - NUM_CORES'(1);
  assign hiReq   = req & ~lowMask;

  for (genvar i = 0; i < NUM_CORES; i++) begin : gLane
    localparam logic [IDX_W-1:0] MyIdx = IDX_W'(i);
    assign addrVec[i] = addr[i*DATA_WIDTH +: DATA_WIDTH];
    assign wdVec[i]   = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign gnt[i]     = granting && (winQ == MyIdx);
    assign done[i]    = (state == DONE) && (winQ == MyIdx);
  end

  // Lowest set bit of hiReq wins; if none at or above ptr, wrap to the
  // lowest set bit of req. Loops run downward so the lowest index is last.
  always_comb begin
    winNext = '0;
    for (int i = NUM_CORES-1; i >= 0; i--)
      if (req[i]) winNext = IDX_W'(i);
    if (|hiReq)
      for (int i = NUM_CORES-1; i >= 0; i--)
        if (hiReq[i]) winNext = IDX_W'(i);
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (|req) stateNext = ACCESS;
      ACCESS:  stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      winQ   <= '0;
      weQ    <= 1'b0;
      addrQ  <= '0;
      wdQ    <= '0;
      rdataQ <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: if (|req) begin
          winQ  <= winNext;
          weQ   <= we[winNext];
          addrQ <= addrVec[winNext];
          wdQ   <= wdVec[winNext];
        end
        ACCESS: if (!weQ) rdataQ <= mem_rd;
        DONE:   ptr <= (winQ == IDX_W'(NUM_CORES-1)) ? '0 : winQ + 1'b1;
        default: ;
      endcase
    end
  end

  // Gating by reset keeps a write in flight from committing when reset
  // lands during ACCESS.
  assign mem_we   = (state == ACCESS) && weQ && !reset;
  assign mem_addr = addrQ;
  assign mem_wd   = wdQ;
  assign rdata    = rdataQ;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level schedule model.
module tb_dmem_arbiter;
  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MAXC = 4096;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req, we;
  logic [N*DW-1:0] addr, wdata;
  logic [N-1:0]    gnt, done;
  logic [DW-1:0]   rdata, mem_addr, mem_wd, mem_rd;
  logic            busy, mem_we;

  dmem_arbiter #(.NUM_CORES(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // shared memory environment
  logic [DW-1:0] envMem [64];
  assign mem_rd = envMem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) envMem[mem_addr[7:2]] <= mem_wd;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int nChk = 0, nPass = 0;
  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Each service is scheduled as two future cycles: an access cycle and a
  // done cycle; the model is free to pick again three cycles after picking.
  typedef struct {
    bit            acc;
    bit            dn;
    logic [N-1:0]  g;
    bit            wr;
    logic [DW-1:0] a;
    logic [DW-1:0] d;
  } slotT;

  slotT          sch [MAXC];
  int            freeAt = 0;
  int            ptrM = 0;
  logic [DW-1:0] expRdata = '0;
  logic [DW-1:0] refMem [64];

  always @(negedge clk) begin
    slotT s;
    s = sch[cyc];
    if (cyc >= 2) begin
      chk("gnt", DW'(gnt), DW'(s.g));
      chk("done", DW'(done), s.dn ? DW'(s.g) : '0);
      chk("busy", DW'(busy), DW'(s.acc | s.dn));
      chk("mem_we", DW'(mem_we), DW'(s.acc & s.wr & !reset));
      chk("rdata", rdata, expRdata);
      if (s.acc) begin
        chk("mem_addr", mem_addr, s.a);
        chk("mem_wd", mem_wd, s.d);
      end
    end
    if (reset) begin
      for (int k = 1; k <= 3; k++) sch[cyc+k] = '{default: 0};
      freeAt   = cyc + 1;
      ptrM     = 0;
      expRdata = '0;
    end else begin
      if (s.acc) begin
        if (s.wr) refMem[s.a[7:2]] = s.d;
        else      expRdata = refMem[s.a[7:2]];
      end
      if (cyc >= freeAt && req != '0) begin
        int win;
        win = -1;
        for (int k = 0; k < N; k++)
          if (win < 0 && req[(ptrM+k)%N]) win = (ptrM+k)%N;
        sch[cyc+1] = '{acc: 1, dn: 0, g: N'(1) << win, wr: we[win],
                       a: addr[win*DW +: DW], d: wdata[win*DW +: DW]};
        sch[cyc+2] = '{acc: 0, dn: 1, g: N'(1) << win, wr: 0, a: '0, d: '0};
        freeAt = cyc + 3;
        ptrM   = (win + 1) % N;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk); endtask
  task automatic setReq(input int i, input bit r, input bit w,
                        input logic [DW-1:0] a, input logic [DW-1:0] d);
    req[i] = r; we[i] = w; addr[i*DW +: DW] = a; wdata[i*DW +: DW] = d;
  endtask

  // random requesters: drop req the cycle after done, re-raise at random
  bit           rndMode = 1'b0;
  logic [N-1:0] dropNext = '0;
  always @(posedge clk) if (rndMode) begin
    #1;
    reset = ($urandom_range(0, 199) == 0);
    for (int i = 0; i < N; i++) begin
      if (dropNext[i]) begin
        req[i] = 1'b0;
        dropNext[i] = 1'b0;
      end else if (!req[i] && $urandom_range(0, 3) == 0)
        setReq(i, 1'b1, 1'($urandom_range(0, 1)),
               DW'($urandom_range(0, 63)) << 2, DW'($urandom()));
    end
  end
  always @(negedge clk) if (rndMode)
    for (int i = 0; i < N; i++) if (done[i]) dropNext[i] = 1'b1;

  // ---------------- directed scenarios ----------------
  initial begin
    int order [$];
    int lastDone, multi, spacingBad, g1Seen;
    req = '0; we = '0; addr = '0; wdata = '0;
    for (int k = 0; k < 64; k++) begin
      envMem[k] = 32'h1000_0000 + DW'(k);
      refMem[k] = 32'h1000_0000 + DW'(k);
    end
    @(posedge clk); @(posedge clk); #1; reset = 1'b0;
    smp();
    chk("rst_busy", DW'(busy), 0);
    chk("rst_gnt", DW'(gnt), 0);
    chk("rst_done", DW'(done), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wd", mem_wd, 0);

    // core 2 writes 0xDEADBEEF to 0x40
    step(); setReq(2, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF); smp();
    chk("wr_t0_we", DW'(mem_we), 0);
    step(); smp();
    chk("wr_t1_we", DW'(mem_we), 1);
    chk("wr_t1_addr", mem_addr, 32'h40);
    chk("wr_t1_wd", mem_wd, 32'hDEADBEEF);
    chk("wr_t1_gnt", DW'(gnt), 32'b0100);
    step(); smp();
    chk("wr_t2_done", DW'(done), 32'b0100);
    chk("wr_t2_we", DW'(mem_we), 0);
    step(); req = '0; smp();
    chk("wr_t3_busy", DW'(busy), 0);
    chk("wr_t3_we", DW'(mem_we), 0);

    // core 2 reads 0x40 back
    step(); setReq(2, 1'b1, 1'b0, 32'h40, 32'h0); smp();
    step(); smp();
    chk("rd_t1_we", DW'(mem_we), 0);
    step(); smp();
    chk("rd_t2_done", DW'(done), 32'b0100);
    chk("rd_t2_rdata", rdata, 32'hDEADBEEF);
    chk("rd_t2_we", DW'(mem_we), 0);
    step(); req = '0; smp();

    // ptr is 3: req 1001 serves core 3 then core 0
    step(); setReq(0, 1'b1, 1'b0, 32'h44, 0); setReq(3, 1'b1, 1'b0, 32'h48, 0); smp();
    step(); smp(); chk("rr3_gnt", DW'(gnt), 32'b1000);
    step(); smp(); chk("rr3_done", DW'(done), 32'b1000);
    step(); req[3] = 1'b0; smp();
    step(); smp(); chk("rr0_gnt", DW'(gnt), 32'b0001);
    step(); smp(); chk("rr0_done", DW'(done), 32'b0001);
    step(); req = '0; smp();

    // all four cores request continuously from reset
    step(); reset = 1'b1; we = '0; req = '1;
    for (int i = 0; i < N; i++) addr[i*DW +: DW] = DW'(i) << 2;
    smp();
    step(); reset = 1'b0;
    lastDone = -1; multi = 0; spacingBad = 0;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) step();
      smp();
      if ($countones(gnt) > 1) multi++;
      if (done != '0) begin
        order.push_back($clog2(done));
        if (lastDone >= 0 && k - lastDone != 3) spacingBad++;
        lastDone = k;
      end
    end
    step(); req = '0; smp();
    chk("rr_count", DW'(order.size()), 6);
    begin
      int expOrd [6] = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6; i++)
        chk($sformatf("rr_order%0d", i), (order.size() > i) ? DW'(order[i]) : 32'hFF, DW'(expOrd[i]));
    end
    chk("rr_spacing", DW'(spacingBad), 0);
    chk("rr_multihot", DW'(multi), 0);

    // reset during ACCESS of a write to 0x80
    step(); setReq(0, 1'b1, 1'b1, 32'h80, 32'hCAFEF00D); smp();
    step(); reset = 1'b1; smp();
    chk("rstw_we", DW'(mem_we), 0);
    step(); reset = 1'b0; req = '0; smp();
    chk("rstw_done", DW'(done), 0);
    chk("rstw_busy", DW'(busy), 0);
    chk("rstw_addr", mem_addr, 0);
    chk("rstw_mem", envMem[32], 32'h1000_0020);
    step(); setReq(0, 1'b1, 1'b0, 32'h80, 0); setReq(3, 1'b1, 1'b0, 32'h84, 0); smp();
    step(); smp(); chk("rstw_ptr0", DW'(gnt), 32'b0001);
    step(); smp();
    chk("rstw_rd_done", DW'(done), 32'b0001);
    chk("rstw_rd_data", rdata, 32'h1000_0020);
    step(); req[0] = 1'b0; smp();
    step(); smp();
    step(); smp(); chk("rstw_c3_done", DW'(done), 32'b1000);
    step(); req = '0; smp();

    // core 1 pulses req during core 0's ACCESS and drops it
    g1Seen = 0;
    step(); setReq(0, 1'b1, 1'b0, 32'h0C, 0); smp();
    step(); setReq(1, 1'b1, 1'b1, 32'h10, 32'h5555_AAAA); smp();
    g1Seen += int'(gnt[1]);
    step(); req[1] = 1'b0; smp();
    g1Seen += int'(gnt[1]);
    chk("pulse_done0", DW'(done), 32'b0001);
    step(); req[0] = 1'b0; smp();
    g1Seen += int'(gnt[1]);
    chk("pulse_busy", DW'(busy), 0);
    step(); smp();
    g1Seen += int'(gnt[1]);
    chk("pulse_gnt1", DW'(g1Seen), 0);
    chk("pulse_mem10", envMem[4], 32'h1000_0004);

    // randomized traffic
    rndMode = 1'b1;
    repeat (1500) @(posedge clk);
    rndMode = 1'b0;
    step(); req = '0; reset = 1'b0;
    repeat (6) step();
    smp();
    for (int k = 0; k < 64; k++) chk($sformatf("mem%0d", k), envMem[k], refMem[k]);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
